// File: rtl/sdram_arbiter.sv
// Post-initialization SDRAM command scheduler: owns the auto-refresh timer, grants one sub-block at a time
// and muxes its command/address/bank onto the SDRAM bus. Define SDRAM_ARB_RR_EN for round-robin write/read.
module sdram_arbiter #(
    parameter int CLK_FREQ_MHz  = 50,
    parameter int REF_PERIOD_NS = 7800
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        init_done,
    input  logic [3:0]  init_cmd,
    input  logic [12:0] init_addr,
    output logic        aref_en,
    input  logic        aref_end,
    input  logic [3:0]  aref_cmd,
    input  logic [12:0] aref_addr,
    input  logic        wr_req,
    output logic        wr_en,
    input  logic        wr_end,
    input  logic [3:0]  wr_cmd,
    input  logic [12:0] wr_addr,
    input  logic [1:0]  wr_ba,
    input  logic        rd_req,
    output logic        rd_en,
    input  logic        rd_end,
    input  logic [3:0]  rd_cmd,
    input  logic [12:0] rd_addr,
    input  logic [1:0]  rd_ba,
    output logic        ref_overrun,
    output logic [3:0]  sdram_cmd,
    output logic [12:0] sdram_addr,
    output logic [1:0]  sdram_ba
);

    localparam int REF_CYCLES = CLK_FREQ_MHz * REF_PERIOD_NS / 1000;
    localparam int CNT_W      = (REF_CYCLES > 1) ? $clog2(REF_CYCLES) : 1;
    localparam logic [CNT_W-1:0] REF_LAST  = CNT_W'(REF_CYCLES - 1);
    localparam logic [3:0]       CMD_NOP   = 4'b0111;
    localparam logic [12:0]      ADDR_IDLE = 13'h1FFF;

    typedef enum logic [2:0] {
        ST_INIT  = 3'd0,
        ST_ARB   = 3'd1,
        ST_AREF  = 3'd2,
        ST_WRITE = 3'd3,
        ST_READ  = 3'd4
    } state_t;

    state_t           state_reg;
    logic             aref_en_reg;
    logic             wr_en_reg;
    logic             rd_en_reg;
    logic [CNT_W-1:0] ref_cnt_reg;
    logic [CNT_W-1:0] ref_cnt_next;
    logic             ref_pending_reg;
    logic             ref_pending_next;
    logic             ref_overrun_reg;
    logic             ref_overrun_next;
    logic             ref_wrap;
    logic             ref_due;
    logic             aref_enter;
    logic             pick_wr;
    logic             pick_rd;
`ifdef SDRAM_ARB_RR_EN
    logic             last_grant_reg;   // 0 = write won last, 1 = read won last
`endif

    // A wrap in ARB counts as due immediately, so the refresh is granted on the cycle after the wrap.
    always_comb begin
        ref_wrap   = (state_reg != ST_INIT) && (ref_cnt_reg == REF_LAST);
        ref_due    = ref_pending_reg || ref_wrap;
        aref_enter = (state_reg == ST_ARB) && ref_due;

        ref_cnt_next = ref_cnt_reg + CNT_W'(1);
        if ((state_reg == ST_INIT) || ref_wrap) begin
            ref_cnt_next = '0;
        end

        ref_pending_next = ref_pending_reg;
        if (aref_enter) begin
            ref_pending_next = 1'b0;
        end else if (ref_wrap) begin
            ref_pending_next = 1'b1;
        end

        ref_overrun_next = ref_wrap && ref_pending_reg && !aref_enter;
    end

    always_comb begin
`ifdef SDRAM_ARB_RR_EN
        if (wr_req && rd_req) begin
            pick_wr = last_grant_reg;
            pick_rd = !last_grant_reg;
        end else begin
            pick_wr = wr_req;
            pick_rd = rd_req;
        end
`else
        pick_wr = wr_req;
        pick_rd = rd_req && !wr_req;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ref_cnt_reg     <= '0;
            ref_pending_reg <= 1'b0;
            ref_overrun_reg <= 1'b0;
        end else begin
            ref_cnt_reg     <= ref_cnt_next;
            ref_pending_reg <= ref_pending_next;
            ref_overrun_reg <= ref_overrun_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= ST_INIT;
            aref_en_reg <= 1'b0;
            wr_en_reg   <= 1'b0;
            rd_en_reg   <= 1'b0;
`ifdef SDRAM_ARB_RR_EN
            last_grant_reg <= 1'b0;
`endif
        end else begin
            case (state_reg)
                ST_INIT: begin
                    if (init_done) begin
                        state_reg <= ST_ARB;
                    end
                end
                ST_ARB: begin
                    if (ref_due) begin
                        state_reg   <= ST_AREF;
                        aref_en_reg <= 1'b1;
                    end else if (pick_wr) begin
                        state_reg <= ST_WRITE;
                        wr_en_reg <= 1'b1;
`ifdef SDRAM_ARB_RR_EN
                        last_grant_reg <= 1'b0;
`endif
                    end else if (pick_rd) begin
                        state_reg <= ST_READ;
                        rd_en_reg <= 1'b1;
`ifdef SDRAM_ARB_RR_EN
                        last_grant_reg <= 1'b1;
`endif
                    end
                end
                ST_AREF: begin
                    if (aref_end) begin
                        state_reg   <= ST_ARB;
                        aref_en_reg <= 1'b0;
                    end
                end
                ST_WRITE: begin
                    if (wr_end) begin
                        state_reg <= ST_ARB;
                        wr_en_reg <= 1'b0;
                    end
                end
                ST_READ: begin
                    if (rd_end) begin
                        state_reg <= ST_ARB;
                        rd_en_reg <= 1'b0;
                    end
                end
                default: begin
                    state_reg   <= ST_INIT;
                    aref_en_reg <= 1'b0;
                    wr_en_reg   <= 1'b0;
                    rd_en_reg   <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        sdram_cmd  = CMD_NOP;
        sdram_addr = ADDR_IDLE;
        sdram_ba   = 2'b00;
        case (state_reg)
            ST_INIT: begin
                sdram_cmd  = init_cmd;
                sdram_addr = init_addr;
            end
            ST_AREF: begin
                sdram_cmd  = aref_cmd;
                sdram_addr = aref_addr;
            end
            ST_WRITE: begin
                sdram_cmd  = wr_cmd;
                sdram_addr = wr_addr;
                sdram_ba   = wr_ba;
            end
            ST_READ: begin
                sdram_cmd  = rd_cmd;
                sdram_addr = rd_addr;
                sdram_ba   = rd_ba;
            end
            default: begin
                sdram_cmd  = CMD_NOP;
                sdram_addr = ADDR_IDLE;
                sdram_ba   = 2'b00;
            end
        endcase
    end

    assign aref_en     = aref_en_reg;
    assign wr_en       = wr_en_reg;
    assign rd_en       = rd_en_reg;
    assign ref_overrun = ref_overrun_reg;

    grant_onehot: assert property (@(posedge clk) disable iff (!rst_n)
        $onehot0({aref_en_reg, wr_en_reg, rd_en_reg}));

endmodule

// File: tb/tb_sdram_arbiter.sv
// Self-checking bench for sdram_arbiter: directed scenarios plus random traffic against a cycle-level model.
module tb_sdram_arbiter;

    localparam int REF = 50 * 7800 / 1000;
`ifdef SDRAM_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif
    localparam int M_INIT = 0, M_ARB = 1, M_AREF = 2, M_WR = 3, M_RD = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        init_done = 1'b0;
    logic [3:0]  init_cmd = 4'b0010;
    logic [12:0] init_addr = 13'h0400;
    logic        aref_end = 1'b0;
    logic [3:0]  aref_cmd = 4'b0001;
    logic [12:0] aref_addr = 13'h0000;
    logic        wr_req = 1'b0, wr_end = 1'b0;
    logic [3:0]  wr_cmd = 4'b0100;
    logic [12:0] wr_addr = 13'h0000;
    logic [1:0]  wr_ba = 2'b00;
    logic        rd_req = 1'b0, rd_end = 1'b0;
    logic [3:0]  rd_cmd = 4'b0101;
    logic [12:0] rd_addr = 13'h0000;
    logic [1:0]  rd_ba = 2'b00;
    logic        aref_en, wr_en, rd_en, ref_overrun;
    logic [3:0]  sdram_cmd;
    logic [12:0] sdram_addr;
    logic [1:0]  sdram_ba;

    int n_cmp = 0;
    int n_fail = 0;

    sdram_arbiter #(.CLK_FREQ_MHz(50), .REF_PERIOD_NS(7800)) dut (
        .clk(clk), .rst_n(rst_n), .init_done(init_done), .init_cmd(init_cmd), .init_addr(init_addr),
        .aref_en(aref_en), .aref_end(aref_end), .aref_cmd(aref_cmd), .aref_addr(aref_addr),
        .wr_req(wr_req), .wr_en(wr_en), .wr_end(wr_end), .wr_cmd(wr_cmd), .wr_addr(wr_addr), .wr_ba(wr_ba),
        .rd_req(rd_req), .rd_en(rd_en), .rd_end(rd_end), .rd_cmd(rd_cmd), .rd_addr(rd_addr), .rd_ba(rd_ba),
        .ref_overrun(ref_overrun), .sdram_cmd(sdram_cmd), .sdram_addr(sdram_addr), .sdram_ba(sdram_ba)
    );

    always #5 clk = ~clk;

    // Reference model: which sub-block owns the bus, cycles since leaving INIT, and the refresh deadline flag.
    int m_mode = M_INIT;
    int m_age = 0;
    bit m_pending = 1'b0, m_overrun = 1'b0, m_last_rd = 1'b0;
    bit m_wrap, m_due, m_enter, m_want_wr, m_want_rd;
    logic [3:0]  exp_cmd;
    logic [12:0] exp_addr;
    logic [1:0]  exp_ba;

    assign m_wrap    = (m_mode != M_INIT) && ((m_age % REF) == REF - 1);
    assign m_due     = m_pending || m_wrap;
    assign m_enter   = (m_mode == M_ARB) && m_due;
    assign m_want_wr = wr_req && (!rd_req || !RR || m_last_rd);
    assign m_want_rd = rd_req && !m_want_wr;
    assign exp_cmd   = (m_mode == M_INIT) ? init_cmd : (m_mode == M_AREF) ? aref_cmd :
                       (m_mode == M_WR) ? wr_cmd : (m_mode == M_RD) ? rd_cmd : 4'b0111;
    assign exp_addr  = (m_mode == M_INIT) ? init_addr : (m_mode == M_AREF) ? aref_addr :
                       (m_mode == M_WR) ? wr_addr : (m_mode == M_RD) ? rd_addr : 13'h1FFF;
    assign exp_ba    = (m_mode == M_WR) ? wr_ba : (m_mode == M_RD) ? rd_ba : 2'b00;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_mode <= M_INIT; m_age <= 0; m_pending <= 1'b0; m_overrun <= 1'b0; m_last_rd <= 1'b0;
        end else begin
            m_age     <= (m_mode == M_INIT) ? 0 : m_age + 1;
            m_pending <= m_enter ? 1'b0 : (m_wrap ? 1'b1 : m_pending);
            m_overrun <= m_wrap && m_pending && !m_enter;
            case (m_mode)
                M_INIT: if (init_done) m_mode <= M_ARB;
                M_ARB: begin
                    if (m_due) m_mode <= M_AREF;
                    else if (m_want_wr) begin m_mode <= M_WR; m_last_rd <= 1'b0; end
                    else if (m_want_rd) begin m_mode <= M_RD; m_last_rd <= 1'b1; end
                end
                M_AREF: if (aref_end) m_mode <= M_ARB;
                M_WR:   if (wr_end) m_mode <= M_ARB;
                M_RD:   if (rd_end) m_mode <= M_ARB;
                default: m_mode <= M_INIT;
            endcase
        end
    end

    task automatic do_reset();
        rst_n = 1'b0; init_done = 1'b0; wr_req = 1'b0; rd_req = 1'b0;
        wr_end = 1'b0; rd_end = 1'b0; aref_end = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        init_cmd = 4'b0010; init_addr = 13'h0400;
        do_reset();
        n_cmp++; if ({aref_en, wr_en, rd_en, ref_overrun} !== 4'b0000) begin n_fail++;
            $display("FAIL reset_grants: aref/wr/rd/ovr=%b required 0000", {aref_en, wr_en, rd_en, ref_overrun}); end
        @(negedge clk);
        n_cmp++; if (sdram_cmd !== 4'b0010 || sdram_addr !== 13'h0400 || sdram_ba !== 2'b00) begin n_fail++;
            $display("FAIL init_follow: cmd=%b addr=%h ba=%b required 0010 0400 00", sdram_cmd, sdram_addr, sdram_ba); end
        n_cmp++; if ({aref_en, wr_en, rd_en} !== 3'b000) begin n_fail++;
            $display("FAIL init_grants: %b required 000", {aref_en, wr_en, rd_en}); end
        init_done = 1'b1;
        @(negedge clk);
        n_cmp++; if (sdram_cmd !== 4'b0111 || sdram_addr !== 13'h1FFF || sdram_ba !== 2'b00) begin n_fail++;
            $display("FAIL arb_nop: cmd=%b addr=%h ba=%b required 0111 1fff 00", sdram_cmd, sdram_addr, sdram_ba); end
        $display("test_reset: done");
    endtask

    task automatic test_write();
        wr_req = 1'b1; wr_cmd = 4'b0100; wr_ba = 2'b10; wr_addr = 13'($urandom);
        @(negedge clk);
        n_cmp++; if (wr_en !== 1'b1 || rd_en !== 1'b0 || aref_en !== 1'b0) begin n_fail++;
            $display("FAIL write_grant: wr/rd/aref=%b%b%b required 100", wr_en, rd_en, aref_en); end
        n_cmp++; if (sdram_cmd !== 4'b0100 || sdram_ba !== 2'b10 || sdram_addr !== wr_addr) begin n_fail++;
            $display("FAIL write_bus: cmd=%b ba=%b addr=%h required 0100 10 %h", sdram_cmd, sdram_ba, sdram_addr, wr_addr); end
        wr_req = 1'b0; rd_end = 1'b1; aref_end = 1'b1;
        @(negedge clk);
        rd_end = 1'b0; aref_end = 1'b0;
        n_cmp++; if (wr_en !== 1'b1) begin n_fail++;
            $display("FAIL foreign_end_ignored: wr_en=%b required 1", wr_en); end
        wr_end = 1'b1;
        @(negedge clk);
        wr_end = 1'b0;
        n_cmp++; if (wr_en !== 1'b0 || sdram_cmd !== 4'b0111 || sdram_addr !== 13'h1FFF) begin n_fail++;
            $display("FAIL write_release: wr_en=%b cmd=%b addr=%h required 0 0111 1fff", wr_en, sdram_cmd, sdram_addr); end
        $display("test_write: done");
    endtask

    // Entered straight after a write grant, so round-robin hands the first contested grant to read.
    task automatic test_both();
        bit first_wr;
        first_wr = !RR;
        wr_cmd = 4'b0100; rd_cmd = 4'b0101; rd_ba = 2'b01;
        wr_req = 1'b1; rd_req = 1'b1;
        @(negedge clk);
        n_cmp++; if (wr_en !== first_wr || rd_en !== !first_wr) begin n_fail++;
            $display("FAIL both_first: wr/rd=%b%b required %b%b", wr_en, rd_en, first_wr, !first_wr); end
        if (first_wr) begin wr_req = 1'b0; wr_end = 1'b1; end else begin rd_req = 1'b0; rd_end = 1'b1; end
        @(negedge clk);
        wr_end = 1'b0; rd_end = 1'b0;
        n_cmp++; if (wr_en !== 1'b0 || rd_en !== 1'b0 || sdram_cmd !== 4'b0111) begin n_fail++;
            $display("FAIL both_gap_nop: wr/rd=%b%b cmd=%b required 00 0111", wr_en, rd_en, sdram_cmd); end
        @(negedge clk);
        n_cmp++; if (wr_en !== !first_wr || rd_en !== first_wr) begin n_fail++;
            $display("FAIL both_second: wr/rd=%b%b required %b%b", wr_en, rd_en, !first_wr, first_wr); end
        n_cmp++; if (sdram_cmd !== (first_wr ? 4'b0101 : 4'b0100)) begin n_fail++;
            $display("FAIL both_second_cmd: cmd=%b required %b", sdram_cmd, first_wr ? 4'b0101 : 4'b0100); end
        wr_req = 1'b0; rd_req = 1'b0; wr_end = 1'b1; rd_end = 1'b1;
        @(negedge clk);
        wr_end = 1'b0; rd_end = 1'b0;
        n_cmp++; if (sdram_cmd !== 4'b0111) begin n_fail++;
            $display("FAIL both_release: cmd=%b required 0111", sdram_cmd); end
        $display("test_both: done");
    endtask

    task automatic test_refresh();
        int first = 0;
        do_reset();
        aref_cmd = 4'b0001; aref_addr = 13'h0ABC;
        init_done = 1'b1;
        for (int c = 1; c <= REF + 10 && first == 0; c++) begin
            @(negedge clk);
            if (aref_en === 1'b1) first = c;
        end
        n_cmp++; if (first != REF + 1) begin n_fail++;
            $display("FAIL refresh_timing: aref_en first in cycle %0d required %0d", first, REF + 1); end
        n_cmp++; if (sdram_cmd !== 4'b0001 || sdram_addr !== 13'h0ABC || sdram_ba !== 2'b00) begin n_fail++;
            $display("FAIL refresh_bus: cmd=%b addr=%h ba=%b required 0001 0abc 00", sdram_cmd, sdram_addr, sdram_ba); end
        aref_end = 1'b1;
        @(negedge clk);
        aref_end = 1'b0;
        n_cmp++; if (aref_en !== 1'b0 || sdram_cmd !== 4'b0111) begin n_fail++;
            $display("FAIL refresh_release: aref_en=%b cmd=%b required 0 0111", aref_en, sdram_cmd); end
        @(negedge clk);
        n_cmp++; if (aref_en !== 1'b0 || ref_overrun !== 1'b0) begin n_fail++;
            $display("FAIL refresh_cleared: aref_en=%b ovr=%b required 0 0", aref_en, ref_overrun); end
        $display("test_refresh: done");
    endtask

    task automatic test_overrun();
        int n_ovr = 0, ovr_cyc = 0, wr_lost = 0;
        do_reset();
        init_done = 1'b1; wr_req = 1'b1;
        for (int c = 1; c <= 2 * REF + 20; c++) begin
            @(negedge clk);
            if (c == 2) wr_req = 1'b0;
            if (ref_overrun === 1'b1) begin n_ovr++; ovr_cyc = c; end
            if (c >= 2 && wr_en !== 1'b1) wr_lost++;
        end
        n_cmp++; if (n_ovr != 1 || ovr_cyc != 2 * REF + 1) begin n_fail++;
            $display("FAIL overrun_pulse: %0d pulses last at cycle %0d required 1 at %0d", n_ovr, ovr_cyc, 2 * REF + 1); end
        n_cmp++; if (wr_lost != 0) begin n_fail++;
            $display("FAIL no_preempt: wr_en low in %0d cycles required 0", wr_lost); end
        rd_req = 1'b1; rd_cmd = 4'b0101; rd_ba = 2'b11; wr_end = 1'b1;
        @(negedge clk);
        wr_end = 1'b0;
        n_cmp++; if ({aref_en, wr_en, rd_en} !== 3'b000 || sdram_cmd !== 4'b0111) begin n_fail++;
            $display("FAIL overrun_gap: aref/wr/rd=%b cmd=%b required 000 0111", {aref_en, wr_en, rd_en}, sdram_cmd); end
        @(negedge clk);
        n_cmp++; if (aref_en !== 1'b1 || rd_en !== 1'b0) begin n_fail++;
            $display("FAIL refresh_before_read: aref/rd=%b%b required 10", aref_en, rd_en); end
        aref_end = 1'b1;
        @(negedge clk);
        aref_end = 1'b0;
        @(negedge clk);
        n_cmp++; if (rd_en !== 1'b1 || sdram_cmd !== 4'b0101 || sdram_ba !== 2'b11) begin n_fail++;
            $display("FAIL read_after_refresh: rd_en=%b cmd=%b ba=%b required 1 0101 11", rd_en, sdram_cmd, sdram_ba); end
        $display("test_overrun: done");
    endtask

    task automatic test_reset_mid_read();
        init_cmd = 4'b0011; init_addr = 13'h0123;
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if ({aref_en, wr_en, rd_en} !== 3'b000) begin n_fail++;
            $display("FAIL async_reset_grants: aref/wr/rd=%b required 000", {aref_en, wr_en, rd_en}); end
        n_cmp++; if (sdram_cmd !== 4'b0011 || sdram_addr !== 13'h0123 || sdram_ba !== 2'b00) begin n_fail++;
            $display("FAIL async_reset_bus: cmd=%b addr=%h ba=%b required 0011 0123 00", sdram_cmd, sdram_addr, sdram_ba); end
        init_done = 1'b0; rd_req = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++; if (sdram_cmd !== 4'b0011 || rd_en !== 1'b0) begin n_fail++;
            $display("FAIL reset_back_to_init: cmd=%b rd_en=%b required 0011 0", sdram_cmd, rd_en); end
        $display("test_reset_mid_read: done");
    endtask

    task automatic test_random();
        int bad = 0;
        do_reset();
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            n_cmp++;
            if (sdram_cmd !== exp_cmd || sdram_addr !== exp_addr || sdram_ba !== exp_ba ||
                aref_en !== (m_mode == M_AREF) || wr_en !== (m_mode == M_WR) ||
                rd_en !== (m_mode == M_RD) || ref_overrun !== m_overrun) begin
                n_fail++; bad++;
                $display("FAIL random_cycle %0d: cmd=%b addr=%h ba=%b en=%b%b%b ovr=%b required %b %h %b %b%b%b %b",
                         c, sdram_cmd, sdram_addr, sdram_ba, aref_en, wr_en, rd_en, ref_overrun,
                         exp_cmd, exp_addr, exp_ba, m_mode == M_AREF, m_mode == M_WR, m_mode == M_RD, m_overrun);
            end
            if (!init_done) init_done = ($urandom_range(0, 3) == 0);
            if (m_mode == M_WR) wr_req = 1'b0; else if (!wr_req) wr_req = ($urandom_range(0, 3) == 0);
            if (m_mode == M_RD) rd_req = 1'b0; else if (!rd_req) rd_req = ($urandom_range(0, 3) == 0);
            aref_end = ($urandom_range(0, 5) == 0);
            wr_end   = ($urandom_range(0, 7) == 0);
            rd_end   = ($urandom_range(0, 7) == 0);
            init_cmd = 4'($urandom); init_addr = 13'($urandom);
            aref_cmd = 4'($urandom); aref_addr = 13'($urandom);
            wr_cmd = 4'($urandom); wr_addr = 13'($urandom); wr_ba = 2'($urandom);
            rd_cmd = 4'($urandom); rd_addr = 13'($urandom); rd_ba = 2'($urandom);
        end
        $display("test_random: 4000 cycles, %0d bad", bad);
    endtask

    initial begin
        test_reset();
        test_write();
        test_both();
        test_refresh();
        test_overrun();
        test_reset_mid_read();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/sdram_arbiter.md
Name: sdram_arbiter

Overview:
- Post-initialization command scheduler for the SDRAM controller. It sits between the initialization sequencer, the auto-refresh, write and read sub-blocks, and the SDRAM command/address pins.
- It owns the auto-refresh interval timer and grants exactly one sub-block at a time.
- It multiplexes the granted sub-block's command, address and bank onto the SDRAM bus.
- Command encoding is {CSn, RASn, CASn, WEn}. NOP = 4'b0111.

Parameters:
- CLK_FREQ_MHz, 50, system clock frequency in MHz.
- REF_PERIOD_NS, 7800, auto-refresh interval in ns.
- REF_CYCLES, CLK_FREQ_MHz*REF_PERIOD_NS/1000 (390 at defaults), refresh timer terminal count. Derived, do not override.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset; asynchronous, active-low.
- init_done  in  1  initialization complete; monotonic once high.
- init_cmd  in  4  command from the initialization sequencer.
- init_addr  in  13  address from the initialization sequencer.
- aref_en  out  1  auto-refresh grant (level).
- aref_end  in  1  auto-refresh sub-block finished (1-cycle pulse).
- aref_cmd  in  4  auto-refresh command.
- aref_addr  in  13  auto-refresh address.
- wr_req  in  1  write request (level, held until granted).
- wr_en  out  1  write grant (level).
- wr_end  in  1  write burst finished (1-cycle pulse).
- wr_cmd  in  4  write command.
- wr_addr  in  13  write address.
- wr_ba  in  2  write bank.
- rd_req, rd_en, rd_end, rd_cmd, rd_addr, rd_ba: read equivalents of the write signals, same widths and directions.
- ref_overrun  out  1  1-cycle pulse when a refresh deadline is missed.
- sdram_cmd  out  4  SDRAM command bus.
- sdram_addr  out  13  SDRAM address bus.
- sdram_ba  out  2  SDRAM bank address.

Behaviour:
- Reset values: state=INIT, all grants 0, ref_overrun 0, ref_pending 0, refresh counter 0.
- FSM states: INIT, ARB, AREF, WRITE, READ. State is one-hot or binary (implementer's choice). The state register and grants are registered.
- INIT:
  - sdram_cmd/addr follow init_cmd/init_addr combinationally; sdram_ba=2'b00.
  - Refresh counter held at 0.
  - When init_done is sampled high, next state is ARB.
- ARB:
  - Bus driven NOP, addr 13'h1FFF, ba 2'b00.
  - Priority evaluated on each edge: ref_pending > wr_req > rd_req.
  - The winner's state and grant take effect the next cycle: request sampled at edge N gives grant high after edge N, i.e. a 1-cycle decision latency.
- AREF / WRITE / READ:
  - The corresponding *_en is held at 1 and the bus muxes that sub-block's cmd/addr/ba. AREF uses ba 2'b00.
  - On the matching *_end sampled high, the grant drops and state returns to ARB after that edge.
  - Every return passes through ARB for at least one cycle, so at least one NOP appears between operations.
  - *_end inputs that do not match the current state are ignored.
- No preemption: a refresh that becomes due during WRITE/READ waits until that operation ends. Requests are never dropped; they are level-held by the requester.
- Refresh timer:
  - Counts 0..REF_CYCLES-1 from the first cycle in ARB onward, free-running and wrapping to 0.
  - On wrap, ref_pending is set.
  - ref_pending is cleared on the edge that enters AREF.
  - If ref_pending is still set at the next wrap, ref_overrun pulses for one cycle and ref_pending stays 1.
  - Simultaneous wrap and AREF entry: the clear wins and no overrun is flagged. The new deadline is then counted from the wrap.
- Grants are mutually exclusive at all times. At most one *_en is high in any cycle.
- Reset mid-operation: all grants drop immediately (asynchronous), state returns to INIT, and the bus returns to following init_cmd.

Optional Feature:
- Macro SDRAM_ARB_RR_EN.
- Defined:
  - Write and read share round-robin priority.
  - A 1-bit last_grant register (reset 0 = write) tracks the last winner.
  - When both wr_req and rd_req are high in ARB, the one not granted last wins.
  - Refresh still has absolute priority.
- Undefined: fixed priority, write over read.

Test Plan:
- Reset release, init_cmd=4'b0010, init_done=0 -> sdram_cmd=4'b0010, all *_en=0; set init_done -> next cycle sdram_cmd=4'b0111, sdram_addr=13'h1FFF.
- wr_req=1 in ARB with wr_cmd=4'b0100, wr_ba=2'b10 -> wr_en=1 one cycle later, sdram_cmd=4'b0100, sdram_ba=2'b10; pulse wr_end -> wr_en=0 and NOP on the next cycle.
- wr_req and rd_req both high from ARB -> wr_en granted first; after wr_end, rd_en granted after exactly one NOP cycle. With SDRAM_ARB_RR_EN: a second simultaneous request after a write grant goes to read.
- 390 cycles in ARB with no requests -> aref_en=1 on cycle 391, ref_pending cleared; aref_end -> back to ARB.
- Hold WRITE (no wr_end) for 800 cycles -> ref_overrun pulses once at the second wrap; after wr_end, AREF is granted before a pending rd_req.
- Assert rst_n=0 during READ -> rd_en=0 immediately, state INIT; bus follows init_cmd.
